// File: rtl/display_scan_mux_pkg.sv
// Shared definitions for the display scan engine and the alarm-compare block.
// Digit vectors are sized for the largest supported display (8 digits).
package display_scan_mux_pkg;

    localparam int   BCD_W      = 4;
    localparam logic ANODE_OFF  = 1'b1;
    localparam int   MAX_DIGITS = 8;

    // Bit i set when digits i..num_digits-1 of snap are all zero; bit 0 never set.
    function automatic logic [MAX_DIGITS-1:0] lead_zero_mask(input logic [BCD_W*MAX_DIGITS-1:0] snap,
                                                             input int num_digits);
        logic [MAX_DIGITS-1:0] mask;
        logic                  all_zero;
        mask     = {MAX_DIGITS{1'b0}};
        all_zero = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < num_digits) begin
                all_zero = all_zero & (snap[i*BCD_W +: BCD_W] == 4'h0);
                mask[i]  = all_zero;
            end else begin
                mask[i]  = 1'b0;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/display_scan_mux_scan_prescaler.sv
// Divide-by-DIV tick generator; counts only while i_en is high and
// flags the enabled cycle on which the count wraps.
module scan_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    output logic o_tick
);

    localparam int             CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == LAST);

    // Free-running modulo-DIV counter, advanced only when enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_en) begin
            if (r_cnt == LAST) begin
                r_cnt <= {CNT_W{1'b0}};
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed 7-segment scan engine: owns the refresh/blink timing,
// snapshots the BCD count once per frame and drives digit value and anodes.
module display_scan_mux
    import display_scan_mux_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_TICKS = 250,
    parameter int SEL_W       = $clog2(NUM_DIGITS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [BCD_W*NUM_DIGITS-1:0] count,
    input  logic [NUM_DIGITS-1:0]       blank_mask,
    input  logic [NUM_DIGITS-1:0]       blink_mask,
    input  logic                        lz_suppress,
    output logic [SEL_W-1:0]            digit_sel,
    output logic [BCD_W-1:0]            digit_val,
    output logic                        digit_blank,
    output logic [NUM_DIGITS-1:0]       anode,
    output logic                        scan_tick
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_DIGITS - 1);

    logic                        w_tick;
    logic                        w_blink_wrap;
    logic [MAX_DIGITS-1:0]       w_lz_mask;
    logic                        w_blank;
    logic [BCD_W-1:0]            w_digit;
    logic [NUM_DIGITS-1:0]       w_anode_on;

    logic [SEL_W-1:0]            r_idx;
    logic [BCD_W*NUM_DIGITS-1:0] r_snap;
    logic                        r_phase;
    logic                        r_first;
    logic [SEL_W-1:0]            r_digit_sel;
    logic [BCD_W-1:0]            r_digit_val;
    logic                        r_digit_blank;
    logic [NUM_DIGITS-1:0]       r_anode;
    logic                        r_scan_tick;

    scan_prescaler #(.DIV(REFRESH_DIV)) u_refresh (
        .clk    (clk),
        .reset  (reset),
        .i_en   (1'b1),
        .o_tick (w_tick)
    );

    scan_prescaler #(.DIV(BLINK_TICKS)) u_blink (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_tick),
        .o_tick (w_blink_wrap)
    );

    // Scan state: digit index, frame snapshot (also on first cycle out of reset) and blink phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx   <= {SEL_W{1'b0}};
            r_snap  <= {(BCD_W*NUM_DIGITS){1'b0}};
            r_phase <= 1'b0;
            r_first <= 1'b1;
        end else begin
            r_first <= 1'b0;
            if (w_tick) begin
                r_idx <= (r_idx == LAST_IDX) ? {SEL_W{1'b0}} : r_idx + SEL_W'(1);
            end
            if (r_first || (w_tick && (r_idx == LAST_IDX))) begin
                r_snap <= count;
            end
            if (w_blink_wrap) begin
                r_phase <= ~r_phase;
            end
        end
    end

    assign w_lz_mask  = lead_zero_mask(32'(r_snap), NUM_DIGITS);
    assign w_blank    = blank_mask[r_idx] | (blink_mask[r_idx] & r_phase) | (lz_suppress & w_lz_mask[r_idx]);
    assign w_digit    = r_snap[r_idx*BCD_W +: BCD_W];
    assign w_anode_on = ~(NUM_DIGITS'(1) << r_idx);

    // Registered display outputs, one cycle behind the scan state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_digit_sel   <= {SEL_W{1'b0}};
            r_digit_val   <= {BCD_W{1'b0}};
            r_digit_blank <= 1'b1;
            r_anode       <= {NUM_DIGITS{ANODE_OFF}};
            r_scan_tick   <= 1'b0;
        end else begin
            r_digit_sel   <= r_idx;
            r_digit_val   <= w_blank ? {BCD_W{1'b0}} : w_digit;
            r_digit_blank <= w_blank;
            r_anode       <= w_blank ? {NUM_DIGITS{ANODE_OFF}} : w_anode_on;
            r_scan_tick   <= w_tick;
        end
    end

    assign digit_sel   = r_digit_sel;
    assign digit_val   = r_digit_val;
    assign digit_blank = r_digit_blank;
    assign anode       = r_anode;
    assign scan_tick   = r_scan_tick;

endmodule

// File: tb/tb_display_scan_mux.sv
// Self-checking bench: arithmetic model of the scan engine compared every cycle,
// plus literal checkpoints, on a 6-digit and a 4-digit instance.
module tb_display_scan_mux;

    typedef struct {
        logic [2:0] sel;
        logic [3:0] val;
        logic       blank;
        logic [7:0] anode;
        logic       tick;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] count1 = 24'h123456;
    logic [5:0]  bm1 = 6'b000000;
    logic [5:0]  blm1 = 6'b000000;
    logic        lz1 = 1'b0;
    logic [15:0] count2 = 16'h4321;

    logic [2:0]  sel1;
    logic [3:0]  val1;
    logic        blank1;
    logic [5:0]  anode1;
    logic        tick1;
    logic [1:0]  sel2;
    logic [3:0]  val2;
    logic        blank2;
    logic [3:0]  anode2;
    logic        tick2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    display_scan_mux #(.NUM_DIGITS(6), .REFRESH_DIV(4), .BLINK_TICKS(3)) dut1 (
        .clk(clk), .reset(reset), .count(count1), .blank_mask(bm1), .blink_mask(blm1),
        .lz_suppress(lz1), .digit_sel(sel1), .digit_val(val1), .digit_blank(blank1),
        .anode(anode1), .scan_tick(tick1)
    );

    display_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(2), .BLINK_TICKS(2)) dut2 (
        .clk(clk), .reset(reset), .count(count2), .blank_mask(4'b0000), .blink_mask(4'b0000),
        .lz_suppress(1'b0), .digit_sel(sel2), .digit_val(val2), .digit_blank(blank2),
        .anode(anode2), .scan_tick(tick2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Output of a scanner that has completed n edges since reset with snapshot snap.
    function automatic exp_t model_out(input int nd, input int r, input int b, input int n,
                                       input logic [31:0] snap, input logic [7:0] bm,
                                       input logic [7:0] blm, input logic lz);
        exp_t        e;
        int          idx;
        int          ph;
        logic [31:0] up;
        logic        bl;
        logic [7:0]  all_on;
        idx    = (n / r) % nd;
        ph     = (n / (r * b)) % 2;
        up     = snap >> (4 * idx);
        bl     = bm[idx] | (blm[idx] & (ph == 1)) | (lz && (idx != 0) && (up == 32'd0));
        all_on = 8'((1 << nd) - 1);
        e.sel   = 3'(idx);
        e.val   = bl ? 4'd0 : up[3:0];
        e.blank = bl;
        e.anode = bl ? all_on : (all_on & ~8'(1 << idx));
        e.tick  = ((n % r) == (r - 1));
        return e;
    endfunction

    function automatic exp_t reset_out(input int nd);
        exp_t e;
        e.sel = 3'd0; e.val = 4'd0; e.blank = 1'b1; e.anode = 8'((1 << nd) - 1); e.tick = 1'b0;
        return e;
    endfunction

    int          n1 = 0, n2 = 0;
    logic [31:0] snap1 = 32'd0, snap2 = 32'd0;
    exp_t        e1, e2;
    logic        mv = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            n1 = 0; snap1 = 32'd0; e1 = reset_out(6);
            n2 = 0; snap2 = 32'd0; e2 = reset_out(4);
        end else begin
            e1 = model_out(6, 4, 3, n1, snap1, 8'(bm1), 8'(blm1), lz1);
            if (n1 == 0 || ((n1 % 4) == 3 && ((n1 / 4) % 6) == 5)) snap1 = 32'(count1);
            n1++;
            e2 = model_out(4, 2, 2, n2, snap2, 8'd0, 8'd0, 1'b0);
            if (n2 == 0 || ((n2 % 2) == 1 && ((n2 / 2) % 4) == 3)) snap2 = 32'(count2);
            n2++;
        end
        mv = 1'b1;
    end

    always @(negedge clk) begin
        if (mv) begin
            chk("sel1",   32'(sel1),   32'(e1.sel));
            chk("val1",   32'(val1),   32'(e1.val));
            chk("blank1", 32'(blank1), 32'(e1.blank));
            chk("anode1", 32'(anode1), 32'(e1.anode[5:0]));
            chk("tick1",  32'(tick1),  32'(e1.tick));
            chk("sel2",   32'(sel2),   32'(e2.sel[1:0]));
            chk("val2",   32'(val2),   32'(e2.val));
            chk("blank2", 32'(blank2), 32'(e2.blank));
            chk("anode2", 32'(anode2), 32'(e2.anode[3:0]));
            chk("tick2",  32'(tick2),  32'(e2.tick));
        end
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        // Basic scan order, tick cadence, mid-frame count change.
        step(3);
        chk("pin_rst_anode", 32'(anode1), 32'h3f);
        chk("pin_rst_blank", 32'(blank1), 32'h1);
        reset = 1'b0;
        step(2);
        chk("pin_d0_val",   32'(val1),   32'h6);
        chk("pin_d0_anode", 32'(anode1), 32'h3e);
        step(2);
        chk("pin_tick_hi",  32'(tick1),  32'h1);
        step(1);
        chk("pin_tick_lo",  32'(tick1),  32'h0);
        chk("pin_d1_val",   32'(val1),   32'h5);
        chk("pin_d1_anode", 32'(anode1), 32'h3d);
        step(3);
        chk("pin4_sel3",    32'(sel2),   32'h3);
        chk("pin4_anode3",  32'(anode2), 32'h7);
        step(1);
        chk("pin4_sel0",    32'(sel2),   32'h0);
        chk("pin4_anode0",  32'(anode2), 32'he);
        step(4);
        count1 = 24'h000000;
        step(7);
        chk("pin_old_snap", 32'(val1),   32'h2);
        step(6);
        chk("pin_new_snap", 32'(val1),   32'h0);
        chk("pin_new_blank", 32'(blank1), 32'h0);

        // Leading-zero suppression.
        reset = 1'b1; lz1 = 1'b1; count1 = 24'h000705;
        step(3);
        reset = 1'b0;
        step(10);
        chk("pin_lz_d2_val",   32'(val1),   32'h7);
        chk("pin_lz_d2_anode", 32'(anode1), 32'h3b);
        step(4);
        chk("pin_lz_d3_blank", 32'(blank1), 32'h1);
        chk("pin_lz_d3_anode", 32'(anode1), 32'h3f);
        count1 = 24'h000000;
        step(12);
        chk("pin_lz0_d0_blank", 32'(blank1), 32'h0);
        chk("pin_lz0_d0_anode", 32'(anode1), 32'h3e);
        step(4);
        chk("pin_lz0_d1_blank", 32'(blank1), 32'h1);

        // Blinking and static blanking.
        reset = 1'b1; lz1 = 1'b0; count1 = 24'h123456; blm1 = 6'b001100;
        step(3);
        reset = 1'b0;
        step(10);
        chk("pin_blink_on",  32'(val1),   32'h4);
        step(4);
        chk("pin_blink_off", 32'(anode1), 32'h3f);
        step(8);
        chk("pin_blink_d5",  32'(val1),   32'h1);
        bm1 = 6'b000001;
        step(4);
        chk("pin_bm_d0",     32'(blank1), 32'h1);
        step(40);

        // Reset mid-scan at idx 4, pre 2, then reload from new count.
        reset = 1'b1; bm1 = 6'b000000; blm1 = 6'b000000; count1 = 24'h123456;
        step(3);
        reset = 1'b0;
        step(18);
        reset = 1'b1; count1 = 24'h654321;
        step(1);
        chk("pin_mid_sel",   32'(sel1),   32'h0);
        chk("pin_mid_anode", 32'(anode1), 32'h3f);
        chk("pin_mid_tick",  32'(tick1),  32'h0);
        step(1);
        reset = 1'b0;
        step(2);
        chk("pin_reload_val", 32'(val1), 32'h1);
        step(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
